// File: rtl/tte_pkg.sv
// Shared definitions for the truth-table extractor.
// Contents:
//   tte_state_t : sweep FSM states.
//   code_width  : truth-table code width, 2**n_in.
//   tte_clog2   : ceiling log2, used to size the phase counter.
package tte_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        OBSERVE = 2'd2,
        FINISH  = 2'd3
    } tte_state_t;

    function automatic int code_width(input int n_in);
        return 2 ** n_in;
    endfunction

    function automatic int tte_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tte_row_timer.sv
// Per-row phase timer for the truth-table extractor.
// A loadable down-counter: load presets the count; otherwise it decrements
// toward zero and rests there. last is high during the final cycle of the
// loaded phase (count == 1).
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   load     : preset the counter with load_val on this edge
//   load_val : phase length in cycles (>= 1)
//   last     : final cycle of the current phase
module tte_row_timer #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          last
);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CW'(1);
        end
    end

    assign last = (cnt_reg == CW'(1));

endmodule

// File: rtl/truth_table_extractor.sv
// Truth-table extractor: sweeps every input row of a combinational function,
// lets each row settle, samples the function output over an observation
// window and assembles the hex truth-table code (row 0 lands in the MSB).
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   start    : begins a sweep when idle (including the cycle after done)
//   stim     : function inputs, stim[N_IN-1] is the MSB of the row index
//   dut_out  : function output, sampled synchronously
//   busy     : sweep in progress
//   done     : one-cycle pulse at the end of a sweep
//   code     : extracted truth table, held until the next accepted start
//   unstable : per-row flag, output changed inside the observation window
//   err      : OR of unstable, valid with code
module truth_table_extractor
    import tte_pkg::*;
#(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter int OBS_CYCLES    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [N_IN-1:0]        stim,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic [(2**N_IN)-1:0]   code,
    output logic [(2**N_IN)-1:0]   unstable,
    output logic                   err
);

    localparam int W    = code_width(N_IN);
    localparam int MAXC = (SETTLE_CYCLES > OBS_CYCLES) ? SETTLE_CYCLES : OBS_CYCLES;
    localparam int CW   = tte_clog2(MAXC + 1);

    tte_state_t      state_reg, state_next;
    logic [N_IN-1:0] row_reg, row_next;
    logic [N_IN-1:0] stim_reg, stim_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic [W-1:0]    code_reg, code_next;
    logic [W-1:0]    unstable_reg, unstable_next;
    logic            err_reg, err_next;
    logic            ref_reg, ref_next;
    logic            first_reg, first_next;

    logic            timer_load;
    logic [CW-1:0]   timer_val;
    logic            timer_last;

    // One-hot select of the code bit owned by the current row (row 0 -> MSB).
    logic [W-1:0]    row_sel;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_row_sel
            assign row_sel[gi] = (row_reg == N_IN'(W - 1 - gi));
        end
    endgenerate

    tte_row_timer #(
        .CW(CW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .last     (timer_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            row_reg      <= '0;
            stim_reg     <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            code_reg     <= '0;
            unstable_reg <= '0;
            err_reg      <= 1'b0;
            ref_reg      <= 1'b0;
            first_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            row_reg      <= row_next;
            stim_reg     <= stim_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            code_reg     <= code_next;
            unstable_reg <= unstable_next;
            err_reg      <= err_next;
            ref_reg      <= ref_next;
            first_reg    <= first_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        row_next      = row_reg;
        stim_next     = stim_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        code_next     = code_reg;
        unstable_next = unstable_reg;
        err_next      = err_reg;
        ref_next      = ref_reg;
        first_next    = first_reg;
        timer_load    = 1'b0;
        timer_val     = CW'(SETTLE_CYCLES);

        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = SETTLE;
                    row_next      = '0;
                    stim_next     = '0;
                    busy_next     = 1'b1;
                    code_next     = '0;
                    unstable_next = '0;
                    err_next      = 1'b0;
                    timer_load    = 1'b1;
                end
            end

            SETTLE: begin
                if (timer_last) begin
                    state_next = OBSERVE;
                    first_next = 1'b1;
                    timer_load = 1'b1;
                    timer_val  = CW'(OBS_CYCLES);
                end
            end

            OBSERVE: begin
                first_next = 1'b0;
                // First sample of the window is the reference; later samples
                // that disagree mark the row unstable.
                if (first_reg) begin
                    ref_next = dut_out;
                end
                for (int i = 0; i < W; i++) begin
                    if (row_sel[i]) begin
                        if (!first_reg && (dut_out != ref_reg)) begin
                            unstable_next[i] = 1'b1;
                        end
                        if (timer_last) begin
                            code_next[i] = dut_out;
                        end
                    end
                end
                if (timer_last) begin
                    if (row_reg == N_IN'(W - 1)) begin
                        state_next = FINISH;
                    end else begin
                        state_next = SETTLE;
                        row_next   = row_reg + N_IN'(1);
                        stim_next  = row_reg + N_IN'(1);
                        timer_load = 1'b1;
                    end
                end
            end

            FINISH: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                err_next   = |unstable_reg;
                stim_next  = '0;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign stim     = stim_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign code     = code_reg;
    assign unstable = unstable_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_truth_table_extractor.sv
module tb_truth_table_extractor;

    localparam int LAT1 = 8 * (4 + 2) + 1;   // default instance
    localparam int LAT2 = 4 * (1 + 1) + 1;   // N_IN=2, 1/1 instance

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] stim;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic [7:0] code;
    logic [7:0] unstable;
    logic       err;

    logic       start2;
    logic [1:0] stim2;
    logic       dut_out2;
    logic       busy2;
    logic       done2;
    logic [3:0] code2;
    logic [3:0] unstable2;
    logic       err2;

    int vectors;
    int miscompares;

    // Behavioural function under test: tgt is the truth table (row 0 at MSB).
    // mode 1 makes row 2 toggle every cycle, driven by k (cycles since accept).
    logic [7:0] tgt;
    int         mode;
    int         k;

    assign dut_out  = (mode == 1 && stim == 3'd2) ? k[0] : tgt[3'd7 - stim];
    assign dut_out2 = stim2[1] ^ stim2[0];

    truth_table_extractor dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stim     (stim),
        .dut_out  (dut_out),
        .busy     (busy),
        .done     (done),
        .code     (code),
        .unstable (unstable),
        .err      (err)
    );

    truth_table_extractor #(
        .N_IN          (2),
        .SETTLE_CYCLES (1),
        .OBS_CYCLES    (1)
    ) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start2),
        .stim     (stim2),
        .dut_out  (dut_out2),
        .busy     (busy2),
        .done     (done2),
        .code     (code2),
        .unstable (unstable2),
        .err      (err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: code bit (7-r) is the function value for row r; a toggling
    // row reports its final sample and is flagged unstable.
    function automatic logic [7:0] model_code(input logic [7:0] t, input int md);
        logic [7:0] c;
        for (int r = 0; r < 8; r++) begin
            c[7 - r] = t[7 - r];
            if (md == 1 && r == 2) c[7 - r] = 1'b1;
        end
        return c;
    endfunction

    function automatic logic [7:0] model_unstable(input int md);
        logic [7:0] u;
        u = 8'h00;
        if (md == 1) u[7 - 2] = 1'b1;
        return u;
    endfunction

    // Called at a negedge. Pulses start, then counts edges until done.
    // lat = cycles from accepting edge to done, -1 on timeout, -2 if reset.
    task automatic sweep(input logic [7:0] t, input int md, input int repulse,
                         input int rst_at, output int lat);
        tgt   = t;
        mode  = md;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k     = 0;
        lat   = -1;
        while (k < 200) begin
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (k == 0) chk("busy_run", busy, 1);
            start = (repulse != 0 && (k == 5 || k == 30)) ? 1'b1 : 1'b0;
            if (k == rst_at) begin
                start = 1'b0;
                rst_n = 1'b0;
                #1;
                chk("rst_stim", stim, 0);
                chk("rst_busy", busy, 0);
                chk("rst_code", code, 0);
                chk("rst_unstable", unstable, 0);
                chk("rst_done", done, 0);
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk("rst_no_done", done, 0);
                end
                rst_n = 1'b1;
                @(negedge clk);
                chk("rst_idle_busy", busy, 0);
                chk("rst_idle_done", done, 0);
                lat = -2;
                break;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
    endtask

    task automatic post(input string tag, input int lat, input logic [7:0] t,
                        input int md, input bit hold);
        logic [7:0] ec;
        logic [7:0] eu;
        ec = model_code(t, md);
        eu = model_unstable(md);
        chk({tag, "_latency"}, lat, LAT1);
        chk({tag, "_code"}, code, ec);
        chk({tag, "_unstable"}, unstable, eu);
        chk({tag, "_err"}, err, (eu != 0) ? 1 : 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_stim"}, stim, 0);
        if (hold) begin
            @(negedge clk);
            chk({tag, "_done_pulse"}, done, 0);
            repeat (2) @(negedge clk);
            chk({tag, "_code_hold"}, code, ec);
        end
    endtask

    initial begin
        int         lat;
        logic [7:0] t;
        vectors     = 0;
        miscompares = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        tgt    = 8'h00;
        mode   = 0;
        k      = 0;

        repeat (2) @(negedge clk);
        chk("reset_stim", stim, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_code", code, 0);
        chk("reset_unstable", unstable, 0);
        chk("reset_err", err, 0);
        chk("reset2_code", code2, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 0xD9 function, single sweep
        sweep(8'hD9, 0, 0, -1, lat);
        post("d9", lat, 8'hD9, 0, 1'b1);

        // constant 0 then constant 1, second start in the done cycle
        sweep(8'h00, 0, 0, -1, lat);
        post("const0", lat, 8'h00, 0, 1'b0);
        sweep(8'hFF, 0, 0, -1, lat);
        post("const1", lat, 8'hFF, 0, 1'b1);

        // row 010 toggles inside its observation window
        t = 8'($urandom);
        sweep(t, 1, 0, -1, lat);
        post("toggle", lat, t, 1, 1'b1);

        // start re-pulsed mid-sweep is ignored
        t = 8'($urandom);
        sweep(t, 0, 1, -1, lat);
        post("repulse", lat, t, 0, 1'b1);

        // reset mid-sweep, then a full sweep
        t = 8'($urandom);
        sweep(t, 0, 0, 20, lat);
        chk("abort_no_done", lat, 32'hFFFF_FFFE);
        t = 8'($urandom);
        sweep(t, 0, 0, -1, lat);
        post("after_rst", lat, t, 0, 1'b1);

        // random functions
        for (int n = 0; n < 4; n++) begin
            t = 8'($urandom);
            sweep(t, 0, int'($urandom_range(0, 1)), -1, lat);
            post("rand", lat, t, 0, 1'b1);
        end

        // N_IN=2 instance with XOR
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = -1;
        for (int c = 0; c < 100; c++) begin
            if (done2 === 1'b1) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        chk("xor_latency", lat, LAT2);
        chk("xor_code", code2, 4'b0110);
        chk("xor_unstable", unstable2, 0);
        chk("xor_err", err2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
